// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
// The optional early-out path is enabled by defining DIV_EARLY_OUT_EN.
package ex_div_pkg;

  localparam int DIV_XLEN = 32;
  localparam logic [DIV_XLEN-1:0] DIV_OVF_MIN = {1'b1, {(DIV_XLEN-1){1'b0}}};

  // Encoding matches funct3[1:0] of the RV32M divide group.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  function automatic logic op_is_rem(input div_op_t o);
    return (o == REM) || (o == REMU);
  endfunction

  function automatic logic op_is_signed(input div_op_t o);
    return (o == DIV) || (o == REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the
// divisor magnitude, keep the difference and set the quotient LSB on no borrow.
module div_step
  import ex_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            borrow;

  // Carry the full partial remainder into the subtraction so the top bit
  // of diff is a true borrow regardless of operand values.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {2'b00, divisor};
  assign borrow  = diff[XLEN+1];

  always_comb begin
    rem_next = shifted[XLEN:0];
    quo_next = {quo[XLEN-2:0], 1'b0};
    if (!borrow) begin
      rem_next = diff[XLEN:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer beside the EX-stage ALU.
// Defining DIV_EARLY_OUT_EN completes |dividend| < |divisor| ops in one cycle.
module ex_div_seq
  import ex_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] OVF_MIN =
    (XLEN == DIV_XLEN) ? XLEN'(DIV_OVF_MIN) : {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state_reg;
  div_op_t          op_reg;
  logic             neg_quo_reg;
  logic             neg_rem_reg;
  logic [XLEN:0]    rem_reg;
  logic [XLEN-1:0]  quo_reg;
  logic [XLEN-1:0]  div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg;
  logic [XLEN-1:0]  result_reg;

  div_op_t          op_in;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             div_zero, ovf, early, special;
  logic [XLEN-1:0]  special_result;
  logic [XLEN:0]    rem_step;
  logic [XLEN-1:0]  quo_step;
  logic [XLEN-1:0]  quo_fix, rem_fix, fix_result;

  assign op_in    = div_op_t'(op);
  assign a_neg    = op_is_signed(op_in) & dividend[XLEN-1];
  assign b_neg    = op_is_signed(op_in) & divisor[XLEN-1];
  assign a_mag    = a_neg ? -dividend : dividend;
  assign b_mag    = b_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = op_is_signed(op_in) && (dividend == OVF_MIN) && (&divisor);

`ifdef DIV_EARLY_OUT_EN
  assign early = !div_zero && !ovf && (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  assign special = div_zero | ovf | early;

  // Results for cases that never enter the iteration.
  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = op_is_rem(op_in) ? dividend : '1;
    else if (ovf)
      special_result = op_is_rem(op_in) ? '0 : OVF_MIN;
    else
      special_result = op_is_rem(op_in) ? dividend : '0;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (div_reg),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  assign quo_fix    = neg_quo_reg ? -quo_reg : quo_reg;
  assign rem_fix    = neg_rem_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];
  assign fix_result = op_is_rem(op_reg) ? rem_fix : quo_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      op_reg      <= DIV;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
      end else begin
        unique case (state_reg)
          IDLE: begin
            if (start) begin
              op_reg      <= op_in;
              neg_quo_reg <= a_neg ^ b_neg;
              neg_rem_reg <= a_neg;
              div_reg     <= b_mag;
              if (special) begin
                result_reg <= special_result;
                done_reg   <= 1'b1;
                state_reg  <= DONE;
              end else begin
                rem_reg   <= '0;
                quo_reg   <= a_mag;
                cnt_reg   <= CNT_W'(XLEN - 1);
                state_reg <= CALC;
              end
            end
          end
          CALC: begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            if (cnt_reg == '0)
              state_reg <= FIX;
            else
              cnt_reg <= cnt_reg - 1'b1;
          end
          FIX: begin
            result_reg <= fix_result;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
          DONE: state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Low in DONE so the pipeline advances while it consumes result.
  assign stall  = (state_reg == IDLE && start && !flush) ||
                  (state_reg == CALC) || (state_reg == FIX);
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed self-checking bench for ex_div_seq: results, latency, stall,
// special cases, flush, mid-operation reset and the early-out option.
module tb_ex_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 34;
`endif

  ex_div_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, check latency, stall span and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit toggle);
    int lat;
    int stalls;
    bit seen;
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    #1;
    check({tag, "_stall_at_start"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; stalls = 0; seen = 1'b0;
    while (lat <= 100) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall) stalls++;
      if (toggle) begin
        start = ~start;
        dividend = $urandom;
        divisor = $urandom;
        op = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_cycles"}, stalls, exp_lat - 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_stall_in_done"}, 32'(stall), 32'd0);
    $display("op %-10s a=0x%08h b=0x%08h result=0x%08h latency=%0d", tag, a, b, result, lat);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Unsigned basics
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34, 1'b0);

    // Signed sign fix-up
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1'b0);
    run_op("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1'b0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 34, 1'b0);
    run_op("div_min_2", OP_DIV, 32'h80000000, 32'd2, 32'hC0000000, 34, 1'b0);
    run_op("rem_m100_7", OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34, 1'b0);

    // Divide by zero and signed overflow
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);

    run_op("divu_max_16", OP_DIVU, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 34, 1'b0);

    // Flush in the 10th CALC cycle
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_result_held", result, 32'h0FFFFFFF);
    $display("op flush      a=0x%08h b=0x%08h result=0x%08h", 32'd1000, 32'd3, result);

    // Normal op after flush, with start/operands toggling during CALC
    run_op("divu_9_3_tog", OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 1'b1);

    // Reset pulled low in the 20th CALC cycle
    @(negedge clk);
    op = OP_REMU; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    $display("op reset      a=0x%08h b=0x%08h result=0x%08h", 32'd1000, 32'd7, result);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op("remu_10_4", OP_REMU, 32'd10, 32'd4, 32'd2, 34, 1'b0);

    // Early-out candidates: same results either way, latency depends on build
    run_op("divu_3_10", OP_DIVU, 32'd3, 32'd10, 32'd0, EARLY_LAT, 1'b0);
    run_op("remu_3_10", OP_REMU, 32'd3, 32'd10, 32'd3, EARLY_LAT, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
- Iterative integer divide sequencer for the EX stage. It executes RV32M DIV/DIVU/REM/REMU, which the single-cycle ALU does not cover.
- It accepts one operation from EX, stalls the pipeline while the radix-2 restoring iteration runs, then presents a registered result with a one-cycle done pulse.
- It sits beside the ALU and is muxed onto the EX result path by the pipeline.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  valid divide op in EX (EX valid & divide decoded)
- op  in  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  XLEN  rs1 value
- divisor  in  XLEN  rs2 value
- flush  in  1  kill in-flight op (branch mispredict/squash)
- stall  out  1  hold IF/ID/EX; combinational
- done  out  1  result valid this cycle, single-cycle pulse
- result  out  XLEN  quotient or remainder, registered

Behaviour:
- Reset: one clock, reset asynchronous and active-low on rst. While rst=0: state=IDLE, done=0, result=0, counter=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1 (and flush=0), latch op, sign flags and operand magnitudes (abs value for DIV/REM, raw for DIVU/REMU).
  - Divisor==0: result = all-ones for DIV/DIVU, dividend for REM/REMU; go to DONE.
  - Signed overflow (op DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF): result = 0x80000000 for DIV, 0 for REM; go to DONE.
  - Otherwise clear the partial remainder, counter=XLEN-1, go to CALC.
- CALC:
  - Each cycle shift {rem,quo} left by 1 and trial-subtract the divisor magnitude.
  - If there is no borrow, keep the difference and set quotient LSB=1.
  - At counter==0 go to FIX; otherwise decrement the counter.
- FIX:
  - Quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend). Signed ops only.
  - Register the selected quotient or remainder into result; go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE. result holds its value until the next completion.
- Latency:
  - Normal op: start sampled in cycle N, done in cycle N+XLEN+2 (N+34 for XLEN=32).
  - Special case: done in cycle N+1.
- stall = (state==IDLE & start & ~flush) | state==CALC | state==FIX. stall is low in DONE so the pipeline advances while consuming result.
- start while not IDLE: ignored. EX is frozen by stall, so it remains asserted but is not re-accepted.
- start in DONE: ignored. The pipeline presents a new op after advancing.
- flush: synchronous and dominant in every state.
  - Next state is IDLE, no done pulse, result unchanged.
  - flush and start in the same cycle: start ignored.
- Reset mid-operation: immediate IDLE, no done pulse.
- Arithmetic: the partial remainder is XLEN+1 bits to catch the borrow. All compares are unsigned on magnitudes.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |dividend| < |divisor| (unsigned magnitudes, divisor≠0, not overflow), result = 0 for DIV/DIVU or dividend for REM/REMU. The op then takes the special-case path and completes in 1 cycle.
- Undefined: such operands take the full XLEN+2 path with identical results.

Decomposition:
- Package ex_div_pkg holds:
  - div_op_t enum (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11)
  - div_state_t enum
  - constant DIV_OVF_MIN (0x80000000 at XLEN=32)
- One combinational sub-module, div_step: inputs rem, quo, divisor magnitude; outputs next rem and next quo for one restoring iteration.
- The FSM, counter and sign fix-up live in ex_div_seq.

Test Plan:
- DIVU 100/7, then REMU 100/7 -> result 14 then 2, each done 34 cycles after start, stall high for 33 cycles.
- DIV -7/2 (0xFFFFFFF9/2) -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. All four have done in the cycle after start.
- Flush asserted in the 10th CALC cycle -> no done, stall low the next cycle. A following DIVU 9/3 -> 3 with normal latency. Toggling start during CALC has no effect.
- rst pulled low in the 20th CALC cycle -> done=0, result=0, stall=0 immediately. After release, REMU 10/4 -> 2.
- With DIV_EARLY_OUT_EN, DIVU 3/10 -> 0 and REMU 3/10 -> 3, both done at N+1. Without the macro, the same results arrive at N+34.
